// File: rtl/alu_seq_ctrl.sv
// Multi-word sequencer around an external 16-bit ALU: one operand word per EXEC cycle,
// with the carry chained between words and the full result assembled in a register.
module alu_seq_ctrl #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [16*WORDS-1:0]   op_a,
  input  logic [16*WORDS-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   result,
  output logic                  carry_out,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic [2:0]            alu_s,
  output logic                  alu_cn,
  input  logic [15:0]           alu_f,
  input  logic                  alu_co
);

  localparam int unsigned W  = 16 * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] OP_BMA = 3'b001;
  localparam logic [2:0] OP_AMB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;

  logic            load;
  logic            last;
  logic            arith;
  logic            sub_op;
  logic [IW+3:0]   base;

  assign last   = (idx_q == IW'(WORDS - 1));
  assign sub_op = (op_q == OP_BMA) || (op_q == OP_AMB);
  assign arith  = sub_op || (op_q == OP_ADD);
  assign base   = {idx_q, 4'b0000};

  // Next-state logic
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXEC;
          load    = 1'b1;
        end
      end
      EXEC: begin
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: current word of the latched operands; subtracts seed the chain with 1
  always_comb begin
    alu_a  = 16'h0000;
    alu_b  = 16'h0000;
    alu_s  = 3'b000;
    alu_cn = 1'b0;
    if (state_q == EXEC) begin
      alu_a  = a_q[base +: 16];
      alu_b  = b_q[base +: 16];
      alu_s  = op_q;
      alu_cn = (idx_q == '0) ? sub_op : carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      op_q      <= 3'b000;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      if (load) begin
        op_q  <= op;
        a_q   <= op_a;
        b_q   <= op_b;
        idx_q <= '0;
      end
      // Unwritten result words keep their previous contents until overwritten
      if (state_q == EXEC) begin
        result[base +: 16] <= alu_f;
        carry_q            <= alu_co;
        idx_q              <= last ? '0 : idx_q + IW'(1);
        if (last) carry_out <= arith ? alu_co : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural 16-bit ALU on the alu_* pins, directed and random
// operations checked against whole-operand arithmetic.
module tb_alu_seq_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2:0]     op;
  logic [W-1:0]   op_a, op_b;
  logic           busy, done;
  logic [W-1:0]   result;
  logic           carry_out;
  logic [15:0]    alu_a, alu_b, alu_f;
  logic [2:0]     alu_s;
  logic           alu_cn, alu_co;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_co(alu_co)
  );

  always #5 clk = ~clk;

  // External 16-bit ALU; carry-out is the no-borrow flag for subtracts
  always_comb begin
    logic [16:0] t;
    t = 17'h0;
    case (alu_s)
      3'b000: t = 17'h0;
      3'b001: t = {1'b0, alu_b} + {1'b0, ~alu_a} + 17'(alu_cn);
      3'b010: t = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'(alu_cn);
      3'b011: t = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cn);
      3'b100: t = {1'b0, alu_a ^ alu_b};
      3'b101: t = {1'b0, alu_a | alu_b};
      3'b110: t = {1'b0, alu_a & alu_b};
      default: t = {1'b0, 16'hFFFF};
    endcase
    alu_f  = t[15:0];
    alu_co = t[16];
  end

  // Whole-operand reference: {carry_out, result}
  function automatic logic [W:0] ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      3'b001: return {b >= a, b - a};
      3'b010: return {a >= b, a - b};
      3'b011: return {1'b0, a} + {1'b0, b};
      3'b100: return {1'b0, a ^ b};
      3'b101: return {1'b0, a | b};
      3'b110: return {1'b0, a & b};
      3'b111: return {1'b0, {W{1'b1}}};
      default: return '0;
    endcase
  endfunction

  // Carry expected into word k: carry out of the low 16*k bits of the full operation
  function automatic logic exp_cn(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    logic [W:0] m, x, y, s;
    logic       c0;
    c0 = (o == 3'b001) || (o == 3'b010);
    if (k == 0) return c0;
    if (o != 3'b001 && o != 3'b010 && o != 3'b011) return 1'b0;
    m = ((W+1)'(1) << (16 * k)) - (W+1)'(1);
    x = {1'b0, (o == 3'b001) ? b : a};
    y = {1'b0, (o == 3'b011) ? b : ((o == 3'b001) ? ~a : ~b)};
    s = (x & m) + (y & m) + (W+1)'(c0);
    return s[16 * k];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One operation from IDLE; returns in the next IDLE cycle so a following call is back-to-back
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    logic [W:0] e;
    e     = ref_op(o, a, b);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    for (int k = 0; k < int'(WORDS); k++) begin
      chk("exec_busy", W'(busy), W'(1'b1));
      chk("exec_done", W'(done), W'(1'b0));
      chk("exec_alu_s", W'(alu_s), W'(o));
      chk("exec_alu_a", W'(alu_a), W'(a[16*k +: 16]));
      chk("exec_alu_b", W'(alu_b), W'(b[16*k +: 16]));
      chk("exec_alu_cn", W'(alu_cn), W'(exp_cn(o, a, b, k)));
      start = hold;
      op    = 3'($urandom);
      op_a  = {$urandom, $urandom};
      op_b  = {$urandom, $urandom};
      @(negedge clk);
    end
    chk("done_pulse", W'(done), W'(1'b1));
    chk("done_busy", W'(busy), W'(1'b1));
    chk("result", result, e[W-1:0]);
    chk("carry_out", W'(carry_out), W'(e[W]));
    chk("idle_alu_pins", W'({alu_a, alu_b, alu_s, alu_cn}), W'(0));
    @(negedge clk);
    chk("idle_done", W'(done), W'(1'b0));
    chk("idle_busy", W'(busy), W'(1'b0));
    chk("hold_result", result, e[W-1:0]);
    chk("hold_carry", W'(carry_out), W'(e[W]));
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; op_a = '0; op_b = '0;
    #1;
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_done", W'(done), W'(1'b0));
    chk("rst_result", result, '0);
    chk("rst_carry", W'(carry_out), W'(1'b0));
    chk("rst_alu_pins", W'({alu_a, alu_b, alu_s, alu_cn}), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'b011, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    run_op(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    run_op(3'b010, 64'h3, 64'h5, 1'b0);
    run_op(3'b010, 64'h5, 64'h3, 1'b0);
    run_op(3'b001, 64'h5, 64'h3, 1'b0);
    run_op(3'b110, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b0);
    run_op(3'b011, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    run_op(3'b111, 64'h0, 64'h0, 1'b1);
    run_op(3'b000, 64'hDEAD_BEEF_0000_1111, 64'h1, 1'b0);

    // Abort mid-operation: reset asserted while word 2 is in flight
    start = 1'b1; op = 3'b011; op_a = 64'h7777_7777_7777_7777; op_b = 64'h1111_1111_1111_1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_alu_a", W'(alu_a), W'(16'h7777));
    rst = 1'b1;
    #1;
    chk("abort_busy", W'(busy), W'(1'b0));
    chk("abort_done", W'(done), W'(1'b0));
    chk("abort_result", result, '0);
    chk("abort_carry", W'(carry_out), W'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", W'(done), W'(1'b0));
      chk("abort_idle", W'(busy), W'(1'b0));
      @(negedge clk);
    end
    run_op(3'b011, 64'h1, 64'h1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 5 == 0) a = '1;
      if (i % 7 == 0) b = a;
      run_op(o, a, b, 1'($urandom));
      if (i % 3 == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
